fa_serial_ctrl: RTL and testbench
=================================

// Module: fa_serial_ctrl
// PURPOSE
//  Bit-serial adder controller. Accepts two WIDTH-bit operands plus carry-in, then drives one
//  shared 1-bit full-adder cell for WIDTH cycles, LSB first. It collects the sum bits and
//  reports the sum and carry-out through a start/ready/done handshake.
//  Area-minimal alternative to a ripple chain; sits between a requester and the 1-bit FA cell.
// PARAMETERS
//  WIDTH    8    operand/sum width in bits; legal range 1..64
// PORTS
//  clk      in   1      single clock; all state updates on the rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; sampled only while ready=1
//  a        in   WIDTH  operand A; sampled on an accepted start only
//  b        in   WIDTH  operand B; sampled on an accepted start only
//  ci       in   1      carry-in; sampled on an accepted start only
//  ready    out  1      1 in IDLE: a start is accepted this cycle
//  busy     out  1      1 in RUN
//  done     out  1      one-cycle pulse in DONE: sum/co valid
//  sum      out  WIDTH  result; held from DONE until the next accepted start completes
//  co       out  1      final carry-out; same validity as sum
// BEHAVIOUR
//  - Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, co=0.
//    Internal shift registers, carry reg and bit counter all clear to 0.
//  - States: IDLE -> RUN on (start & ready). RUN -> DONE when bit_cnt==WIDTH-1 at that edge.
//    DONE -> IDLE unconditionally after one cycle. No other transitions.
//  - Accept edge k: a_sh<=a, b_sh<=b, c_reg<=ci, bit_cnt<=0, state<=RUN.
//  - Each RUN edge: FA cell inputs are a_sh[0], b_sh[0] and c_reg.
//    a_sh and b_sh shift right one bit.
//    s_sh <= {fa_s, s_sh[WIDTH-1:1]}, c_reg <= fa_co, bit_cnt++.
//  - On the final RUN edge (k+WIDTH): sum <= {fa_s, s_sh[WIDTH-1:1]}, co <= fa_co, state <= DONE.
//  - Latency: done is high in the cycle following edge k+WIDTH; ready returns after edge k+WIDTH+1.
//    Throughput: one operation per WIDTH+2 cycles.
//  - Arithmetic: {co,sum} == a + b + ci, mod 2^(WIDTH+1); no overflow flag.
//  - bit_cnt width: max(1, $clog2(WIDTH)). WIDTH=1 means exactly one RUN cycle.
//  - start while busy or done is ignored: no re-sample, no queueing, no error.
//  - a/b/ci changes after acceptance have no effect on the operation in flight.
//  - sum/co update only on the final RUN edge; never partial values on the outputs.
//  - rst at any time (including mid-RUN) wins over all other events at that edge.
//    It returns to reset values, the in-flight operation is abandoned, and no done pulse is issued.
//  - rst and start together: rst wins; start is not accepted.
//  - ready, busy and done are mutually exclusive and decoded from the state register (glitch-free).
// STRUCTURE
//  - Shared package fa_pkg:
//    - state typedef fa_state_t = {FA_IDLE=2'd0, FA_RUN=2'd1, FA_DONE=2'd2}
//    - FA_DEFAULT_WIDTH = 8
//    - 2'd3 is illegal and recovers to FA_IDLE
//  - One sub-module: fa_bit_cell (combinational 1-bit full adder: s, co from a, b, ci), instanced once.
//  - Top holds the FSM, bit counter, operand/sum shift registers, carry register and output registers.
// TESTING
//  1. Reset: rst=1 for 2 cycles, then 0
//     -> ready=1, busy=0, done=0, sum=0, co=0; no done pulse for 20 idle cycles.
//  2. WIDTH=8, a=8'h5A, b=8'h3C, ci=0, one-cycle start
//     -> busy for 8 cycles, then done pulse, sum=8'h96, co=0, ready high the next cycle.
//  3. Carry extremes:
//     a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1.
//     a=8'hFF, b=8'hFF, ci=1 -> sum=8'hFF, co=1.
//     a=0, b=0, ci=1 -> sum=8'h01, co=0.
//  4. Accept a=8'h10, b=8'h20. Pulse start with a=8'hFF, b=8'hFF in RUN cycle 3 and again in DONE
//     -> both ignored; result sum=8'h30, co=0; exactly one done pulse.
//  5. rst pulsed in RUN cycle 4 of a=8'hAA, b=8'h55
//     -> IDLE and reset values next cycle, no done pulse.
//     Following op a=8'h01, b=8'h01 -> sum=8'h02.
//  6. start held high, 200 random ops, WIDTH=8 and WIDTH=1
//     -> done every WIDTH+2 cycles; each {co,sum} equals a+b+ci; sum/co stable between done pulses.

Source files
------------

// File: rtl/fa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fa_pkg
// Brief   : Shared types and constants for the bit-serial adder controller.
// Revision: 1.0 - initial release
// ============================================================================
package fa_pkg;

    localparam int FA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        FA_IDLE = 2'd0,
        FA_RUN  = 2'd1,
        FA_DONE = 2'd2
    } fa_state_t;

endpackage
`default_nettype wire

// File: rtl/fa_serial_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fa_serial_ctrl_if
// Brief   : Requester-side start/ready/done handshake of the serial adder.
// Revision: 1.0 - initial release
// ============================================================================
interface fa_serial_ctrl_if
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             co;

    modport master (
        output start, a, b, ci,
        input  ready, busy, done, sum, co
    );

    modport slave (
        input  start, a, b, ci,
        output ready, busy, done, sum, co
    );
endinterface
`default_nettype wire

// File: rtl/fa_bit_cell.sv
`default_nettype none
// ============================================================================
// Module  : fa_bit_cell
// Brief   : Combinational 1-bit full adder shared by the serial controller.
// Revision: 1.0 - initial release
// ============================================================================
module fa_bit_cell (
    input  wire logic i_a,
    input  wire logic i_b,
    input  wire logic i_ci,
    output logic      o_s,
    output logic      o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule
`default_nettype wire

// File: rtl/fa_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fa_serial_ctrl
// Brief   : Bit-serial adder controller: LSB-first, one FA cell, WIDTH cycles.
// Revision: 1.0 - initial release
// ============================================================================
module fa_serial_ctrl
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input wire logic         clk,
    input wire logic         rst,
    fa_serial_ctrl_if.slave  bus
);
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    fa_state_t          r_state;
    fa_state_t          w_next_state;
    logic               w_ready;
    logic               w_busy;
    logic               w_done;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_s_sh;
    logic [WIDTH-1:0]   w_s_next;
    logic               r_c;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_co;
    logic               w_fa_s;
    logic               w_fa_co;
    logic               w_last;

    fa_bit_cell u_cell (
        .i_a  (r_a_sh[0]),
        .i_b  (r_b_sh[0]),
        .i_ci (r_c),
        .o_s  (w_fa_s),
        .o_co (w_fa_co)
    );

    assign w_last = (r_bit_cnt == c_CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB; a single-bit adder has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_single
            assign w_s_next = w_fa_s;
        end else begin : g_multi
            assign w_s_next = {w_fa_s, r_s_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FA_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            FA_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) w_next_state = FA_RUN;
            end
            FA_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next_state = FA_DONE;
            end
            FA_DONE: begin
                w_done       = 1'b1;
                w_next_state = FA_IDLE;
            end
            default: w_next_state = FA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_s_sh    <= '0;
            r_c       <= 1'b0;
            r_bit_cnt <= '0;
            r_sum     <= '0;
            r_co      <= 1'b0;
        end else if (r_state == FA_IDLE) begin
            if (bus.start) begin
                r_a_sh    <= bus.a;
                r_b_sh    <= bus.b;
                r_c       <= bus.ci;
                r_bit_cnt <= '0;
            end
        end else if (r_state == FA_RUN) begin
            r_a_sh    <= r_a_sh >> 1;
            r_b_sh    <= r_b_sh >> 1;
            r_s_sh    <= w_s_next;
            r_c       <= w_fa_co;
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            // Outputs move only once the whole word is assembled.
            if (w_last) begin
                r_sum <= w_s_next;
                r_co  <= w_fa_co;
            end
        end
    end

    assign bus.ready = w_ready;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.sum   = r_sum;
    assign bus.co    = r_co;
endmodule
`default_nettype wire

// File: tb/tb_fa_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fa_serial_ctrl
// Brief   : Self-checking bench for fa_serial_ctrl at WIDTH=8 and WIDTH=1.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fa_serial_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fa_serial_ctrl_if #(.WIDTH(8)) bus8 ();
    fa_serial_ctrl_if #(.WIDTH(1)) bus1 ();

    fa_serial_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    fa_serial_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] exp_sum;
        logic       exp_co;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a negedge with the WIDTH=8 DUT idle; returns the same way.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic eco, input string nm);
        int busy_n;
        int n;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.ci    = ci;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        bus8.ci    = ~ci;
        busy_n = 0;
        n      = 0;
        while (!bus8.done && n < 40) begin
            if (bus8.busy) busy_n++;
            @(negedge clk);
            n++;
        end
        chk({nm, " done"}, 64'(bus8.done), 64'd1);
        chk({nm, " busy_cycles"}, 64'(busy_n), 64'd8);
        chk({nm, " sum"}, 64'(bus8.sum), 64'(es));
        chk({nm, " co"}, 64'(bus8.co), 64'(eco));
        @(negedge clk);
        chk({nm, " ready_after"}, 64'(bus8.ready), 64'd1);
    endtask

    initial begin
        int         dn;
        int         ops;
        int         last_cyc;
        logic       have;
        logic [8:0] exp8;
        logic [8:0] held8;
        logic [1:0] exp1;
        logic [1:0] held1;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;

        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst ready", 64'(bus8.ready), 64'd1);
        chk("rst busy", 64'(bus8.busy), 64'd0);
        chk("rst done", 64'(bus8.done), 64'd0);
        chk("rst sum", 64'(bus8.sum), 64'd0);
        chk("rst co", 64'(bus8.co), 64'd0);
        chk("rst ready w1", 64'(bus1.ready), 64'd1);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.done || bus1.done) dn++;
        end
        chk("idle no done", 64'(dn), 64'd0);

        // Directed table
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].exp_sum, vecs[i].exp_co,
                   $sformatf("vec%0d", i));

        // Starts during RUN and DONE are ignored
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.ci = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.ci = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 20 && !bus8.done; i++) @(negedge clk);
        chk("ign done seen", 64'(bus8.done), 64'd1);
        chk("ign sum", 64'(bus8.sum), 64'h30);
        chk("ign co", 64'(bus8.co), 64'd0);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        chk("ign ready", 64'(bus8.ready), 64'd1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) dn++;
        end
        chk("ign no extra op", 64'(dn), 64'd0);
        chk("ign sum held", 64'(bus8.sum), 64'h30);

        // Reset mid-RUN abandons the operation
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.ci = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst ready", 64'(bus8.ready), 64'd1);
        chk("midrst busy", 64'(bus8.busy), 64'd0);
        chk("midrst sum", 64'(bus8.sum), 64'd0);
        chk("midrst co", 64'(bus8.co), 64'd0);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.done) dn++;
        end
        chk("midrst no done", 64'(dn), 64'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_rst");

        // Back-to-back random ops, WIDTH=8
        ops = 0; last_cyc = 0; have = 1'b0; exp8 = '0; held8 = '0;
        bus8.start = 1'b1;
        for (int cyc = 0; cyc < 3000 && ops < 200; cyc++) begin
            bus8.a  = 8'($urandom);
            bus8.b  = 8'($urandom);
            bus8.ci = 1'($urandom);
            if (bus8.ready) exp8 = 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.ci);
            @(negedge clk);
            if (bus8.done) begin
                chk("rnd8 result", 64'({bus8.co, bus8.sum}), 64'(exp8));
                if (ops > 0) chk("rnd8 period", 64'(cyc - last_cyc), 64'd10);
                last_cyc = cyc;
                held8    = {bus8.co, bus8.sum};
                have     = 1'b1;
                ops++;
            end else if (have) begin
                chk("rnd8 hold", 64'({bus8.co, bus8.sum}), 64'(held8));
            end
        end
        bus8.start = 1'b0;
        chk("rnd8 op count", 64'(ops), 64'd200);

        // Back-to-back random ops, WIDTH=1
        ops = 0; last_cyc = 0; have = 1'b0; exp1 = '0; held1 = '0;
        bus1.start = 1'b1;
        for (int cyc = 0; cyc < 1000 && ops < 200; cyc++) begin
            bus1.a  = 1'($urandom);
            bus1.b  = 1'($urandom);
            bus1.ci = 1'($urandom);
            if (bus1.ready) exp1 = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.ci);
            @(negedge clk);
            if (bus1.done) begin
                chk("rnd1 result", 64'({bus1.co, bus1.sum}), 64'(exp1));
                if (ops > 0) chk("rnd1 period", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                held1    = {bus1.co, bus1.sum};
                have     = 1'b1;
                ops++;
            end else if (have) begin
                chk("rnd1 hold", 64'({bus1.co, bus1.sum}), 64'(held1));
            end
        end
        bus1.start = 1'b0;
        chk("rnd1 op count", 64'(ops), 64'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
